// File: rtl/beat_accumulator.sv
// Sums groups of up to BEATS unsigned input beats (closed early by last_in) and presents each
// {sum, count} result on a registered valid/ready port; upstream stalls only while a result waits.
module beat_accumulator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned SUM_WIDTH  = DATA_WIDTH + $clog2(BEATS),
  parameter int unsigned CNT_WIDTH  = $clog2(BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  last_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [SUM_WIDTH-1:0]  sum_out,
  output logic [CNT_WIDTH-1:0]  count_out
);

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  state_e               state_q, state_d;
  logic [SUM_WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_next;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 beat_acc, res_acc, closes;

  // acc/cnt are always zero in StDone, so a beat taken alongside a result accept
  // naturally starts a fresh group through the same datapath.
  always_comb begin
    ready_in  = (state_q == StAccum) || ready_out;
    valid_out = (state_q == StDone);
    beat_acc  = valid_in && ready_in;
    res_acc   = valid_out && ready_out;
    acc_next  = acc_q + SUM_WIDTH'(data_in);
    cnt_next  = cnt_q + CNT_WIDTH'(1);
    closes    = (cnt_next == CNT_WIDTH'(BEATS)) || last_in;

    state_d = res_acc ? StAccum : state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    count_d = count_q;

    if (beat_acc) begin
      if (closes) begin
        state_d = StDone;
        sum_d   = acc_next;
        count_d = cnt_next;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign sum_out   = sum_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_beat_accumulator.sv
// Bench for beat_accumulator: BEATS=4 and BEATS=1 instances share one stimulus stream and are
// each compared against a group-sum reference model every cycle.
module tb_beat_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, last_in, ready_out;
  logic [31:0] data_in;

  logic        ready_in4, valid_out4;
  logic [33:0] sum4;
  logic [2:0]  cnt4;
  logic        ready_in1, valid_out1;
  logic [31:0] sum1;
  logic [0:0]  cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: partial group and pending result.
  int              beats_p [2] = '{4, 1};
  bit              pend    [2];
  longint unsigned part    [2];
  int              nb      [2];
  longint unsigned rsum    [2];
  int              rcnt    [2];

  always #5 clk = ~clk;

  beat_accumulator #(.DATA_WIDTH(32), .BEATS(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in4),
    .data_in   (data_in),
    .last_in   (last_in),
    .valid_out (valid_out4),
    .ready_out (ready_out),
    .sum_out   (sum4),
    .count_out (cnt4)
  );

  beat_accumulator #(.DATA_WIDTH(32), .BEATS(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in1),
    .data_in   (data_in),
    .last_in   (last_in),
    .valid_out (valid_out1),
    .ready_out (ready_out),
    .sum_out   (sum1),
    .count_out (cnt1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0;
      part[i] = 0;
      nb[i]   = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit rdy, bacc;
    rdy  = !pend[i] || ready_out;
    bacc = valid_in && rdy;
    if (pend[i] && ready_out) pend[i] = 1'b0;
    if (bacc) begin
      part[i] += longint'(data_in);
      nb[i]++;
      if (nb[i] == beats_p[i] || last_in) begin
        pend[i] = 1'b1;
        rsum[i] = part[i];
        rcnt[i] = nb[i];
        part[i] = 0;
        nb[i]   = 0;
      end
    end
  endtask

  task automatic check_dut(input int i);
    logic [63:0] v, r, s, c;
    if (i == 0) begin
      v = 64'(valid_out4); r = 64'(ready_in4); s = 64'(sum4); c = 64'(cnt4);
    end else begin
      v = 64'(valid_out1); r = 64'(ready_in1); s = 64'(sum1); c = 64'(cnt1);
    end
    check_eq($sformatf("valid_out_b%0d", beats_p[i]), v, 64'(pend[i]));
    check_eq($sformatf("ready_in_b%0d", beats_p[i]), r, 64'(!pend[i] || ready_out));
    if (pend[i]) begin
      check_eq($sformatf("sum_b%0d", beats_p[i]), s, rsum[i]);
      check_eq($sformatf("count_b%0d", beats_p[i]), c, 64'(rcnt[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid4"}, 64'(valid_out4), 64'd0);
    check_eq({tag, "_sum4"},   64'(sum4),       64'd0);
    check_eq({tag, "_count4"}, 64'(cnt4),       64'd0);
    check_eq({tag, "_valid1"}, 64'(valid_out1), 64'd0);
    check_eq({tag, "_sum1"},   64'(sum1),       64'd0);
    check_eq({tag, "_count1"}, 64'(cnt1),       64'd0);
  endtask

  // Drive one cycle of inputs, then check outputs and advance the model at the falling edge.
  task automatic cycle(input bit v, input logic [31:0] d, input bit l, input bit ro);
    @(posedge clk);
    #1;
    valid_in  = v;
    data_in   = d;
    last_in   = l;
    ready_out = ro;
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    model_step(0);
    model_step(1);
  endtask

  // Reset pulse placed off both clock edges; outputs must clear before any edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    valid_in = 1'b0;
    last_in  = 1'b0;
    #4;
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    reset     = 1'b0;
    valid_in  = 1'b0;
    last_in   = 1'b0;
    ready_out = 1'b1;
    data_in   = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    #2;
    reset = 1'b1;

    // Full group back-to-back, then early close, then another full group.
    for (int k = 1; k <= 4; k++) cycle(1'b1, 32'(k), 1'b0, 1'b1);
    cycle(1'b1, 32'd5, 1'b0, 1'b1);
    cycle(1'b1, 32'd7, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd1, 1'b0, 1'b1);
    // Largest beats: sum must not wrap.
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("max_sum", 64'(sum4), 64'h3_FFFF_FFFC);
    // Backpressure with valid_in held high while a result waits.
    for (int k = 1; k <= 4; k++) cycle(1'b1, 32'(k + 10), 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b1, 32'd8, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd9, 1'b0, 1'b1);
    // BEATS=1 continuous stream.
    cycle(1'b1, 32'd3, 1'b0, 1'b1);
    cycle(1'b1, 32'd9, 1'b0, 1'b1);
    cycle(1'b1, 32'd2, 1'b0, 1'b1);
    // Reset mid-group discards the partial sum.
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, 32'd100, 1'b0, 1'b1);
    cycle(1'b1, 32'd200, 1'b0, 1'b1);
    async_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd1, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("post_reset_sum", 64'(sum4), 64'd4);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) != 0);
      if (n == 150 || n == 290) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
